scene_painter: RTL and testbench

SCENE_PAINTER -- requirements
Module: scene_painter

---
 rtl/scene_painter_pkg.sv | 72 +++++++
 rtl/scene_painter_raster_cnt.sv | 55 +++++
 rtl/scene_painter.sv | 133 +++++++++++++
 tb/tb_scene_painter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scene_painter_pkg.sv
// Shared constants, payload types and per-cell colour selection for scene_painter.
// Optional shadow row under the bottle is built only when PAINT_SHADOW_EN is defined.
package scene_painter_pkg;

  localparam int unsigned WIDTH     = 640;
  localparam int unsigned PX_WIDTH  = WIDTH >> 2;
  localparam int unsigned PX_HEIGHT = 120;
  localparam int unsigned BOTTLE_W  = 4;
  localparam int unsigned BOTTLE_H  = 10;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 3;
  localparam int unsigned SW = 9;

  localparam logic [CW-1:0] CODE_BG     = CW'(0);
  localparam logic [CW-1:0] CODE_BOTTLE = CW'(1);
  localparam logic [CW-1:0] CODE_PLAT   = CW'(2);
  localparam logic [CW-1:0] CODE_SHADOW = CW'(6);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAINT,
    ST_FINISH
  } paint_state_e;

  typedef struct packed {
    logic [XW-1:0] bottle_x;
    logic [YW-1:0] bottle_y;
    logic [XW-1:0] plat0_x;
    logic [XW-1:0] plat0_w;
    logic [XW-1:0] plat1_x;
    logic [XW-1:0] plat1_w;
    logic [YW-1:0] plat_y;
  } scene_t;

  // Half-open interval test; 9-bit operands keep lo+len from wrapping.
  function automatic logic in_span(logic [SW-1:0] v, logic [SW-1:0] lo, logic [SW-1:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

  function automatic logic [CW-1:0] cell_code(scene_t s, logic [XW-1:0] x, logic [YW-1:0] y);
    logic [SW-1:0] xs;
    logic [SW-1:0] ys;
    logic          in_bx;
    logic          in_by;
    logic          in_plat;
    logic [CW-1:0] code;
    xs      = SW'(x);
    ys      = SW'(y);
    in_bx   = in_span(xs, SW'(s.bottle_x), SW'(BOTTLE_W));
    in_by   = in_span(ys, SW'(s.bottle_y), SW'(BOTTLE_H));
    in_plat = (ys >= SW'(s.plat_y)) &&
              (in_span(xs, SW'(s.plat0_x), SW'(s.plat0_w)) ||
               in_span(xs, SW'(s.plat1_x), SW'(s.plat1_w)));
    if (in_bx && in_by) begin
      code = CODE_BOTTLE;
    end else if (in_plat) begin
      code = CODE_PLAT;
    end else begin
      code = CODE_BG;
    end
`ifdef PAINT_SHADOW_EN
    if ((code == CODE_BG) && in_bx && (ys == SW'(s.bottle_y) + SW'(BOTTLE_H))) begin
      code = CODE_SHADOW;
    end
`endif
    return code;
  endfunction

endpackage

// File: rtl/scene_painter_raster_cnt.sv
// Row-major x/y raster counter with a running linear address (adds only, no multiply).
module paint_raster_cnt
  import scene_painter_pkg::*;
(
  input  logic          dclk,
  input  logic          clr,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;

  // Wraps to the origin after the last cell so the next frame starts at 0.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (adv) begin
      if (x_q == XW'(PX_WIDTH - 1)) begin
        x_d = '0;
        if (y_q == YW'(PX_HEIGHT - 1)) begin
          y_d    = '0;
          addr_d = '0;
        end else begin
          y_d    = y_q + YW'(1);
          addr_d = addr_q + AW'(1);
        end
      end else begin
        x_d    = x_q + XW'(1);
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = addr_q;

endmodule

// File: rtl/scene_painter.sv
// Repaints a 160x120 cell frame (bottle over two platforms) into frame memory, one cell per clock.
// Define PAINT_SHADOW_EN to paint a shadow row directly beneath the bottle.
module scene_painter
  import scene_painter_pkg::*;
(
  input  logic          dclk,
  input  logic          clr,
  input  logic          start,
  input  logic [7:0]    bottle_x,
  input  logic [6:0]    bottle_y,
  input  logic [7:0]    plat0_x,
  input  logic [7:0]    plat0_w,
  input  logic [7:0]    plat1_x,
  input  logic [7:0]    plat1_w,
  input  logic [6:0]    plat_y,
  output logic [15:0]   wmemaddr,
  output logic [2:0]    wmemdata,
  output logic          wmem_we,
  output logic          busy,
  output logic          done
);

  paint_state_e  state_q, state_d;
  scene_t        scene_q, scene_d;
  scene_t        scene_live_c;
  scene_t        scene_eff_c;
  logic [AW-1:0] wmemaddr_q, wmemaddr_d;
  logic [CW-1:0] wmemdata_q, wmemdata_d;
  logic          wmem_we_q, wmem_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          adv_c;
  logic [CW-1:0] code_c;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic [AW-1:0] cnt_addr;

  paint_raster_cnt u_raster (
    .dclk (dclk),
    .clr  (clr),
    .adv  (adv_c),
    .x    (cnt_x),
    .y    (cnt_y),
    .addr (cnt_addr)
  );

  always_comb begin
    scene_live_c.bottle_x = bottle_x;
    scene_live_c.bottle_y = bottle_y;
    scene_live_c.plat0_x  = plat0_x;
    scene_live_c.plat0_w  = plat0_w;
    scene_live_c.plat1_x  = plat1_x;
    scene_live_c.plat1_w  = plat1_w;
    scene_live_c.plat_y   = plat_y;
  end

  // Cell 0 is emitted on the start edge itself, before the latched copy exists.
  assign scene_eff_c = (state_q == ST_IDLE) ? scene_live_c : scene_q;
  assign code_c      = cell_code(scene_eff_c, cnt_x, cnt_y);

  // Counter points at the next cell to emit; returning to 0 in PAINT means the frame is out.
  always_comb begin
    state_d    = state_q;
    scene_d    = scene_q;
    wmemaddr_d = '0;
    wmemdata_d = '0;
    wmem_we_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    adv_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = ST_PAINT;
          scene_d    = scene_live_c;
          busy_d     = 1'b1;
          wmem_we_d  = 1'b1;
          wmemaddr_d = cnt_addr;
          wmemdata_d = code_c;
          adv_c      = 1'b1;
        end
      end
      ST_PAINT: begin
        busy_d = 1'b1;
        if (cnt_addr == '0) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          wmem_we_d  = 1'b1;
          wmemaddr_d = cnt_addr;
          wmemdata_d = code_c;
          adv_c      = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      scene_q    <= '0;
      wmemaddr_q <= '0;
      wmemdata_q <= '0;
      wmem_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scene_q    <= scene_d;
      wmemaddr_q <= wmemaddr_d;
      wmemdata_q <= wmemdata_d;
      wmem_we_q  <= wmem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wmemaddr = wmemaddr_q;
  assign wmemdata = wmemdata_q;
  assign wmem_we  = wmem_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_scene_painter.sv
// Scoreboard bench for scene_painter: expected writes queued per frame, monitor pops on every write.
module tb_scene_painter;

`ifdef PAINT_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam int COLS   = 160;
  localparam int ROWS   = 120;
  localparam int NCELLS = COLS * ROWS;

  logic        dclk = 1'b0;
  logic        clr;
  logic        start;
  logic [7:0]  bottle_x, plat0_x, plat0_w, plat1_x, plat1_w;
  logic [6:0]  bottle_y, plat_y;
  logic [15:0] wmemaddr;
  logic [2:0]  wmemdata;
  logic        wmem_we, busy, done;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  img[NCELLS];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  m_bx, m_by, m_p0x, m_p0w, m_p1x, m_p1w, m_py;

  always #20 dclk = ~dclk;

  scene_painter dut (
    .dclk     (dclk),
    .clr      (clr),
    .start    (start),
    .bottle_x (bottle_x),
    .bottle_y (bottle_y),
    .plat0_x  (plat0_x),
    .plat0_w  (plat0_w),
    .plat1_x  (plat1_x),
    .plat1_w  (plat1_w),
    .plat_y   (plat_y),
    .wmemaddr (wmemaddr),
    .wmemdata (wmemdata),
    .wmem_we  (wmem_we),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int model(input int x, input int y);
    if (x >= m_bx && x < m_bx + 4 && y >= m_by && y < m_by + 10) return 1;
    if (y >= m_py && ((x >= m_p0x && x < m_p0x + m_p0w) || (x >= m_p1x && x < m_p1x + m_p1w)))
      return 2;
    if (SHADOW && y == m_by + 10 && x >= m_bx && x < m_bx + 4) return 6;
    return 0;
  endfunction

  // Monitor: every presented write is popped and compared; done must close a fully written frame.
  always @(negedge dclk) begin
    if (wmem_we) begin
      wr_cnt++;
      if (int'(wmemaddr) < NCELLS) img[wmemaddr] = int'(wmemdata);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr %0d data %0d required no write", wmemaddr, wmemdata);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (int'(wmemaddr) != mon_e.addr || int'(wmemdata) != mon_e.data) begin
          errors++;
          $display("FAIL write actual addr %0d data %0d required addr %0d data %0d",
                   wmemaddr, wmemdata, mon_e.addr, mon_e.data);
        end
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_frame_complete", exp_q.size(), 0);
      chk("done_without_we", int'(wmem_we), 0);
    end
  end

  task automatic set_coords(input int bx, input int by, input int p0x, input int p0w,
                            input int p1x, input int p1w, input int py);
    bottle_x = 8'(bx);
    bottle_y = 7'(by);
    plat0_x  = 8'(p0x);
    plat0_w  = 8'(p0w);
    plat1_x  = 8'(p1x);
    plat1_w  = 8'(p1w);
    plat_y   = 7'(py);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, int'(wmemaddr), 0);
    chk({tag, "_data"}, int'(wmemdata), 0);
    chk({tag, "_we"}, int'(wmem_we), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // mode 0: plain frame; 1: start + coordinate change at cycle 500 and start in FINISH; 2: clr at cycle 7000
  task automatic run_frame(input int bx, input int by, input int p0x, input int p0w,
                           input int p1x, input int p1w, input int py, input int mode);
    int n, w0, d0;
    @(negedge dclk);
    m_bx = bx; m_by = by; m_p0x = p0x; m_p0w = p0w; m_p1x = p1x; m_p1w = p1w; m_py = py;
    set_coords(bx, by, p0x, p0w, p1x, p1w, py);
    for (int i = 0; i < NCELLS; i++) img[i] = 7;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        exp_q.push_back('{y * COLS + x, model(x, y)});
    w0 = wr_cnt;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge dclk);
    start = 1'b0;
    n = 1;
    chk("first_cycle_busy", int'(busy), 1);
    chk("first_cycle_we", int'(wmem_we), 1);
    chk("first_cycle_addr", int'(wmemaddr), 0);
    while (done !== 1'b1 && n < 20000) begin
      if (mode == 2 && n == 7000) begin
        @(posedge dclk);
        #2 clr = 1'b1;
        #1 check_outputs_zero("abort");
        exp_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge dclk);
        clr = 1'b0;
        repeat (30) @(negedge dclk);
        chk("abort_no_writes", wr_cnt - w0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_busy", int'(busy), 0);
        return;
      end
      if (mode == 1 && n == 500) begin
        set_coords(0, 0, 60, 10, 70, 10, 5);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge dclk);
      n++;
    end
    start = 1'b0;
    chk("done_cycle", n, NCELLS + 1);
    chk("finish_busy", int'(busy), 1);
    if (mode == 1) start = 1'b1;
    @(negedge dclk);
    start = 1'b0;
    chk("after_finish_busy", int'(busy), 0);
    chk("after_finish_done", int'(done), 0);
    repeat (5) @(negedge dclk);
    chk("frame_write_count", wr_cnt - w0, NCELLS);
    chk("frame_done_count", done_cnt - d0, 1);
    chk("frame_queue_empty", exp_q.size(), 0);
    chk("idle_we", int'(wmem_we), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    set_coords(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge dclk);
    check_outputs_zero("reset");
    clr = 1'b0;
    repeat (2) @(negedge dclk);

    // Reference scene
    run_frame(10, 20, 0, 40, 100, 30, 100, 0);
    chk("bottle_3210", img[3210], 1);
    chk("plat_16005", img[16005], 2);
    chk("bg_0", img[0], 0);
    chk("bg_19199", img[19199], 0);
    for (int i = 4810; i <= 4813; i++) chk("shadow_row", img[i], SHADOW ? 6 : 0);

    // Bottle over platform, with mid-frame start/coordinate noise
    run_frame(20, 95, 0, 40, 100, 30, 100, 1);
    chk("overlap_16020", img[16020], 1);
    chk("overlap_16663", img[16663], 1);
    chk("plat_below_bottle_16820", img[16820], 2);
    chk("bottle_above_plat_15860", img[15860], 1);

    // Abort mid-frame
    run_frame(10, 20, 0, 40, 100, 30, 100, 2);

    // Restart from 0 with edge-clipped shapes
    run_frame(158, 50, 150, 20, 250, 20, 118, 0);
    for (int x = 150; x < 160; x++) chk("clip_plat_row119", img[119 * COLS + x], 2);
    for (int x = 0; x < 10; x++) chk("no_wrap_row119", img[119 * COLS + x], 0);
    chk("clip_plat_row118", img[118 * COLS + 159], 2);
    chk("clip_bottle_8158", img[8158], 1);
    chk("no_wrap_bottle_8160", img[8160], 0);
    chk("no_wrap_bottle_8161", img[8161], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
